// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and default geometry for the on-chip SRAM arbiter.
package onchip_mem_arb_pkg;

   localparam int DEF_ADDR_W = 13;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 6500;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } arb_state_e;

   typedef logic mst_idx_t;

endpackage

// File: rtl/onchip_mem_rr_arb.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the master not granted last.
module onchip_mem_rr_arb
   import onchip_mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  mst_idx_t   last_grant_i,
   input  logic       enable_i,
   output logic       grant_valid_o,
   output mst_idx_t   grant_idx_o
);

   always_comb begin
      grant_valid_o = enable_i & (|req_i);
      if (req_i == 2'b11) begin
         grant_idx_o = ~last_grant_i;
      end else begin
         grant_idx_o = req_i[1];
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin sharing of one single-port on-chip SRAM between two Avalon-MM masters, 1-cycle reads.
// Define ONCHIP_MEM_ARB_CLEAR_EN to zero-fill the whole array after reset before serving masters.
module onchip_mem_arbiter
   import onchip_mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int BE_W   = DATA_W / 8,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   arb_state_e        state_q, state_d;
   mst_idx_t          last_grant_q, rd_owner_q;
   logic              rd_pend_q, rd_oor_q;
   logic [1:0]        req;
   logic              run_en, grant_valid;
   mst_idx_t          grant_idx;
   logic [ADDR_W-1:0] sel_addr, clr_addr;
   logic [BE_W-1:0]   sel_be;
   logic [DATA_W-1:0] sel_wdata, rd_data;
   logic              sel_wr, sel_rd, sel_oor, clearing;

   assign req    = {m1_read | m1_write, m0_read | m0_write};
   assign run_en = (state_q == RUN) && !reset;

   onchip_mem_rr_arb u_rr_arb (
      .req_i         (req),
      .last_grant_i  (last_grant_q),
      .enable_i      (run_en),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
   );

   // A write with read also set wins; the read is silently dropped.
   always_comb begin
      sel_addr  = grant_idx ? m1_address    : m0_address;
      sel_be    = grant_idx ? m1_byteenable : m0_byteenable;
      sel_wdata = grant_idx ? m1_writedata  : m0_writedata;
      sel_wr    = grant_idx ? m1_write      : m0_write;
      sel_rd    = (grant_idx ? m1_read : m0_read) & ~sel_wr;
      sel_oor   = {1'b0, sel_addr} >= DEPTH_LIM;
   end

`ifdef ONCHIP_MEM_ARB_CLEAR_EN
   localparam arb_state_e        RST_STATE = CLEAR;
   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] clr_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clr_cnt_q <= '0;
      end else if (state_q == CLEAR) begin
         clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      end
   end

   assign clr_addr = clr_cnt_q;
   assign clearing = (state_q == CLEAR) && !reset;
`else
   localparam arb_state_e RST_STATE = RUN;

   assign clr_addr = '0;
   assign clearing = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR: begin
`ifdef ONCHIP_MEM_ARB_CLEAR_EN
            if (clr_cnt_q == CLR_LAST) begin
               state_d = RUN;
            end
`else
            state_d = RUN;
`endif
         end
         RUN: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RST_STATE;
         last_grant_q <= 1'b1;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 1'b0;
         rd_oor_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= grant_valid & sel_rd;
         if (grant_valid) begin
            last_grant_q <= grant_idx;
         end
         if (grant_valid & sel_rd) begin
            rd_owner_q <= grant_idx;
            rd_oor_q   <= sel_oor;
         end
      end
   end

   // Out-of-range commands still go out with chipselect low so the SRAM ignores them.
   always_comb begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      if (clearing) begin
         mem_address    = clr_addr;
         mem_byteenable = '1;
         mem_chipselect = 1'b1;
         mem_write      = 1'b1;
      end else if (grant_valid) begin
         mem_address    = sel_addr;
         mem_byteenable = sel_be;
         mem_writedata  = sel_wdata;
         mem_chipselect = ~sel_oor;
         mem_write      = sel_wr;
      end
   end

   assign mem_clken = 1'b1;

   assign m0_waitrequest = !(grant_valid && (grant_idx == 1'b0));
   assign m1_waitrequest = !(grant_valid && (grant_idx == 1'b1));

   assign rd_data          = rd_oor_q ? '0 : mem_readdata;
   assign m0_readdata      = rd_data;
   assign m1_readdata      = rd_data;
   assign m0_readdatavalid = rd_pend_q && (rd_owner_q == 1'b0);
   assign m1_readdatavalid = rd_pend_q && (rd_owner_q == 1'b1);

endmodule
